axi_rd: RTL and testbench

- Single-beat AXI4 read master; read-direction counterpart of the single-beat write master.
- Accepts read requests (address only) into an internal request FIFO and issues one AR beat per request.
- Returns each R beat to the requester as a one-cycle data/response pulse, in request order.
- Used by the PCIe tester to read back test patterns and registers over the same AXI interconnect.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_req_fifo.sv | 82 ++++++++
 rtl/axi_rd.sv | 190 +++++++++++++++++++
 tb/tb_axi_rd.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Brief    : Shared AXI encodings and read-master state type.
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

    typedef enum logic [1:0] {
        AR_IDLE = 2'd0,
        AR_POP  = 2'd1,
        AR_SEND = 2'd2
    } ar_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEF   = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEF    = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/axi_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi_req_fifo
// Brief    : Synchronous FIFO with registered read data (pop in n, data in n+1).
// Revision : 1.0 - initial release
// ============================================================================
module axi_req_fifo #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int                  DEPTH     = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] C_DEPTH   = {1'b1, {LOG2_DEPTH{1'b0}}};
    localparam logic [LOG2_DEPTH:0] C_CNT_ONE = {{LOG2_DEPTH{1'b0}}, 1'b1};
    localparam logic [LOG2_DEPTH-1:0] C_PTR_ONE = {{(LOG2_DEPTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic [WIDTH-1:0]      rd_data_q, rd_data_d;
    logic                  w_push;
    logic                  w_pop;

    assign full    = (count_q == C_DEPTH);
    assign empty   = (count_q == '0);
    assign rd_data = rd_data_q;

    // Requests against a full or empty FIFO are ignored here; the caller decides what that means.
    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d  = rd_ptr_q + C_PTR_ONE;
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd
// Brief    : Single-beat AXI4 read master with request FIFO and in-order returns.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH    = 8,
    parameter int LOG2_DEPTH      = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic                      req,
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic                      req_full,
    output logic                      rd_valid,
    output logic [AXI_DATA_WIDTH-1:0] rd_data,
    output logic [1:0]                rd_resp,
    output logic                      ovf,
    output logic                      proto_err,
    output logic                      busy
);

    localparam int               OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] C_MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] C_OUT_ONE  = OUT_W'(1);
    localparam logic [2:0]       C_ARSIZE   = 3'($clog2(AXI_STRB_WIDTH));

    ar_state_e                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                      arvalid_q, arvalid_d;
    logic [OUT_W-1:0]          outstanding_q, outstanding_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [1:0]                rd_resp_q, rd_resp_d;
    logic                      ovf_q, ovf_d;
    logic                      proto_err_q, proto_err_d;

    logic                      w_fifo_pop;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [AXI_ADDR_WIDTH-1:0] w_fifo_dout;
    logic                      w_ar_hs;
    logic                      w_r_beat;
    logic                      w_rid_unused;

    axi_req_fifo #(
        .WIDTH      (AXI_ADDR_WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (req),
        .wr_data (addr),
        .full    (w_fifo_full),
        .rd_en   (w_fifo_pop),
        .rd_data (w_fifo_dout),
        .empty   (w_fifo_empty)
    );

    // Single ID, in-order slave: RID carries no information for this master.
    assign w_rid_unused = ^m_axi_rid;

    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = C_ARSIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE_DEF;
    assign m_axi_arprot  = AXI_PROT_DEF;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rst_n;

    assign req_full  = w_fifo_full;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_resp   = rd_resp_q;
    assign ovf       = ovf_q;
    assign proto_err = proto_err_q;
    assign busy      = !w_fifo_empty || (state_q != AR_IDLE) || (outstanding_q != '0);

    assign w_ar_hs  = arvalid_q && m_axi_arready;
    assign w_r_beat = m_axi_rvalid && m_axi_rready;

    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        arvalid_d     = arvalid_q;
        outstanding_d = outstanding_q;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        rd_resp_d     = rd_resp_q;
        ovf_d         = ovf_q || (req && w_fifo_full);
        proto_err_d   = proto_err_q;
        w_fifo_pop    = 1'b0;

        case (state_q)
            AR_IDLE: begin
                if (!w_fifo_empty && (outstanding_q < C_MAX_OUT)) begin
                    w_fifo_pop = 1'b1;
                    state_d    = AR_POP;
                end
            end
            AR_POP: begin
                araddr_d  = w_fifo_dout;
                arvalid_d = 1'b1;
                state_d   = AR_SEND;
            end
            AR_SEND: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = AR_IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = AR_IDLE;
            end
        endcase

        // A beat that arrives with nothing outstanding is still forwarded but flagged.
        if (w_r_beat) begin
            rd_valid_d = 1'b1;
            rd_data_d  = m_axi_rdata;
            rd_resp_d  = m_axi_rresp;
            if (!m_axi_rlast || (outstanding_q == '0)) begin
                proto_err_d = 1'b1;
            end
        end

        case ({w_ar_hs, w_r_beat})
            2'b10: outstanding_d = outstanding_q + C_OUT_ONE;
            2'b01: begin
                if (outstanding_q != '0) begin
                    outstanding_d = outstanding_q - C_OUT_ONE;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= AR_IDLE;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            outstanding_q <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_resp_q     <= AXI_RESP_OKAY;
            ovf_q         <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            araddr_q      <= araddr_d;
            arvalid_q     <= arvalid_d;
            outstanding_q <= outstanding_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            rd_resp_q     <= rd_resp_d;
            ovf_q         <= ovf_d;
            proto_err_q   <= proto_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd
// Brief    : Directed scoreboard bench for the single-beat AXI read master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [IW-1:0] rid = '0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'b00;
    logic          rlast = 1'b1;
    logic          rvalid = 1'b0;
    logic          rready;
    logic          req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          req_full;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic          ovf;
    logic          proto_err;
    logic          busy;

    always #5 clk = ~clk;

    axi_rd dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_axi_arid    (arid),
        .m_axi_araddr  (araddr),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_arburst (arburst),
        .m_axi_arlock  (arlock),
        .m_axi_arcache (arcache),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rid     (rid),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rlast   (rlast),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .req           (req),
        .addr          (addr),
        .req_full      (req_full),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_resp       (rd_resp),
        .ovf           (ovf),
        .proto_err     (proto_err),
        .busy          (busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rd_exp_t;

    rd_exp_t       exp_rd [$];
    logic [AW-1:0] exp_ar [$];

    int n_checks  = 0;
    int n_errs    = 0;
    int ar_hs_cnt = 0;
    int rd_cnt    = 0;
    int r_sent    = 0;

    logic          ar_pend      = 1'b0;
    logic [AW-1:0] ar_pend_addr = '0;

    logic [DW-1:0] out_data [8] = '{32'h0000_1000, 32'h0000_2004, 32'h0000_3008, 32'h0000_400C,
                                    32'h0000_5010, 32'h0000_6014, 32'h0000_7018, 32'h0000_801C};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_errs++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    // AR and read-return monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            ar_pend = 1'b0;
        end else begin
            if (ar_pend) begin
                check("ar_hold_valid", {63'd0, arvalid}, 64'd1);
                check("ar_hold_addr", {48'd0, araddr}, {48'd0, ar_pend_addr});
            end
            if (arvalid && arready) begin
                ar_hs_cnt++;
                if (exp_ar.size() == 0) fail_now("ar_unexpected", {48'd0, araddr});
                else check("ar_addr", {48'd0, araddr}, {48'd0, exp_ar.pop_front()});
                check("ar_fields", {35'd0, arid, arlen, arsize, arburst, arlock, arcache, arprot},
                      {35'd0, 8'h00, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010});
            end
            ar_pend      = arvalid && !arready;
            ar_pend_addr = araddr;
            if (rd_valid) begin
                rd_exp_t e;
                rd_cnt++;
                if (exp_rd.size() == 0) begin
                    fail_now("rd_unexpected", {32'd0, rd_data});
                end else begin
                    e = exp_rd.pop_front();
                    check("rd_data", {32'd0, rd_data}, {32'd0, e.data});
                    check("rd_resp", {62'd0, rd_resp}, {62'd0, e.resp});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [AW-1:0] a);
        tick();
        req  = 1'b1;
        addr = a;
        tick();
        req  = 1'b0;
    endtask

    task automatic send_r(input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
        rd_exp_t e;
        tick();
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        e.data = d;
        e.resp = resp;
        exp_rd.push_back(e);
        r_sent++;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b1;
    endtask

    task automatic wait_ar(input int target, input int budget, input string name);
        int i = 0;
        while (ar_hs_cnt < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (ar_hs_cnt < target) fail_now(name, 64'(ar_hs_cnt));
    endtask

    task automatic wait_owed(input int budget);
        int i = 0;
        while (ar_hs_cnt <= r_sent && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (ar_hs_cnt <= r_sent) fail_now("ar_timeout", 64'(ar_hs_cnt));
    endtask

    task automatic wait_arvalid(input int budget);
        int i = 0;
        while (!arvalid && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!arvalid) fail_now("arvalid_timeout", 64'(arvalid));
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (busy) fail_now("idle_timeout", 64'(busy));
        repeat (3) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int rb;

        // Reset state
        #12;
        check("rst_arvalid", {63'd0, arvalid}, 64'd0);
        check("rst_araddr", {48'd0, araddr}, 64'd0);
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_rd_resp", {62'd0, rd_resp}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_proto_err", {63'd0, proto_err}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_req_full", {63'd0, req_full}, 64'd0);
        check("rst_rready", {63'd0, rready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rready_run", {63'd0, rready}, 64'd1);

        // Single read
        arready = 1'b1;
        b  = ar_hs_cnt;
        rb = rd_cnt;
        exp_ar.push_back(16'h0010);
        do_req(16'h0010);
        wait_ar(b + 1, 20, "single_ar_timeout");
        tick();
        send_r(32'hDEADBEEF, 2'b00, 1'b1);
        wait_idle(20);
        check("single_rd_pulses", 64'(rd_cnt - rb), 64'd1);
        check("single_busy", {63'd0, busy}, 64'd0);

        // AR back-pressure
        arready = 1'b0;
        b  = ar_hs_cnt;
        rb = rd_cnt;
        exp_ar.push_back(16'h0024);
        do_req(16'h0024);
        wait_arvalid(10);
        repeat (10) tick();
        check("bp_no_hs", 64'(ar_hs_cnt - b), 64'd0);
        check("bp_no_rd", 64'(rd_cnt - rb), 64'd0);
        check("bp_arvalid", {63'd0, arvalid}, 64'd1);
        arready = 1'b1;
        wait_ar(b + 1, 5, "bp_ar_timeout");
        repeat (3) tick();
        check("bp_one_hs", 64'(ar_hs_cnt - b), 64'd1);
        send_r(32'h12345678, 2'b00, 1'b1);
        wait_idle(20);
        check("bp_rd_pulses", 64'(rd_cnt - rb), 64'd1);

        // Outstanding limit
        b  = ar_hs_cnt;
        rb = rd_cnt;
        for (int i = 0; i < 8; i++) exp_ar.push_back(16'(4 * i));
        for (int i = 0; i < 8; i++) begin
            tick();
            req  = 1'b1;
            addr = 16'(4 * i);
        end
        tick();
        req = 1'b0;
        repeat (40) tick();
        check("lim_hs_count", 64'(ar_hs_cnt - b), 64'd4);
        check("lim_arvalid", {63'd0, arvalid}, 64'd0);
        check("lim_no_rd", 64'(rd_cnt - rb), 64'd0);
        for (int i = 0; i < 8; i++) begin
            wait_owed(40);
            send_r(out_data[i], 2'b00, 1'b1);
        end
        wait_idle(60);
        check("lim_hs_total", 64'(ar_hs_cnt - b), 64'd8);
        check("lim_rd_total", 64'(rd_cnt - rb), 64'd8);
        check("lim_proto_err", {63'd0, proto_err}, 64'd0);

        // FIFO overflow: 33 accepted (32 queued + 1 held on AR), 7 dropped
        arready = 1'b0;
        b  = ar_hs_cnt;
        rb = rd_cnt;
        for (int i = 0; i < 33; i++) exp_ar.push_back(16'h0100 + 16'(4 * i));
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 32) check("ovf_full_before", {63'd0, req_full}, 64'd0);
            if (i == 33) check("ovf_full_at", {63'd0, req_full}, 64'd1);
            req  = 1'b1;
            addr = 16'h0100 + 16'(4 * i);
        end
        tick();
        req = 1'b0;
        check("ovf_sticky", {63'd0, ovf}, 64'd1);
        check("ovf_req_full", {63'd0, req_full}, 64'd1);
        arready = 1'b1;
        for (int i = 0; i < 33; i++) begin
            wait_owed(60);
            send_r(32'hA000_0000 | 32'(i), 2'b00, 1'b1);
        end
        wait_idle(60);
        check("ovf_hs_total", 64'(ar_hs_cnt - b), 64'd33);
        check("ovf_rd_total", 64'(rd_cnt - rb), 64'd33);
        check("ovf_ar_drained", 64'(exp_ar.size()), 64'd0);

        // Error responses
        b = ar_hs_cnt;
        exp_ar.push_back(16'h0200);
        do_req(16'h0200);
        wait_ar(b + 1, 20, "err_ar_timeout");
        send_r(32'hBAD0_0002, 2'b10, 1'b1);
        wait_idle(20);
        check("slverr_no_proto", {63'd0, proto_err}, 64'd0);
        send_r(32'h5555_AAAA, 2'b00, 1'b1);
        check("unsolicited_proto", {63'd0, proto_err}, 64'd1);
        tick();
        check("unsolicited_busy", {63'd0, busy}, 64'd0);

        // Async reset with one AR pending and two outstanding
        r_sent = ar_hs_cnt;
        b = ar_hs_cnt;
        exp_ar.push_back(16'h0300);
        exp_ar.push_back(16'h0304);
        exp_ar.push_back(16'h0308);
        for (int i = 0; i < 3; i++) begin
            tick();
            req  = 1'b1;
            addr = 16'h0300 + 16'(4 * i);
        end
        tick();
        req = 1'b0;
        wait_ar(b + 2, 30, "mid_ar_timeout");
        tick();
        arready = 1'b0;
        wait_arvalid(10);
        tick();
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        check("pre_rst_ovf", {63'd0, ovf}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_arvalid", {63'd0, arvalid}, 64'd0);
        check("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("mid_rst_ovf", {63'd0, ovf}, 64'd0);
        check("mid_rst_proto_err", {63'd0, proto_err}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        exp_ar.delete();
        exp_rd.delete();
        r_sent = ar_hs_cnt;
        repeat (2) tick();
        @(negedge clk);
        rst_n   = 1'b1;
        arready = 1'b1;
        b  = ar_hs_cnt;
        rb = rd_cnt;
        exp_ar.push_back(16'h0400);
        do_req(16'h0400);
        wait_ar(b + 1, 20, "post_rst_ar_timeout");
        send_r(32'hCAFE_F00D, 2'b01, 1'b1);
        wait_idle(20);
        check("post_rst_rd", 64'(rd_cnt - rb), 64'd1);
        check("post_rst_proto", {63'd0, proto_err}, 64'd0);

        // Missing rlast
        b = ar_hs_cnt;
        exp_ar.push_back(16'h0408);
        do_req(16'h0408);
        wait_ar(b + 1, 20, "rlast_ar_timeout");
        send_r(32'h0BAD_1A57, 2'b00, 1'b0);
        check("rlast_proto", {63'd0, proto_err}, 64'd1);
        wait_idle(20);

        check("end_rd_queue", 64'(exp_rd.size()), 64'd0);
        check("end_ar_queue", 64'(exp_ar.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
